mul_unit: RTL and testbench
===========================

Name: mul_unit

Overview:
- Iterative shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU instructions. It sits in the EX stage beside the ALU.
- Each iteration it feeds its partial-product high word and the multiplicand to a 32-bit ripple-carry adder instance (cin tied 0). It consumes the adder's sum and cout as the next accumulator value.
- It stalls the pipeline via busy until the 32-bit result is ready.

Parameters:
- XLEN, 32, operand and result width. Only 32 is supported; the adder instance is fixed at 32 bits.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  2  00=MUL (low word), 01=MULH (s×s), 10=MULHSU (rs1 signed × rs2 unsigned), 11=MULHU (u×u)
- a  input  32  rs1 operand; sampled with start
- b  input  32  rs2 operand; sampled with start
- kill  input  1  synchronous pipeline flush
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when result is valid
- result  output  32  product word selected by op

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, busy=0, done=0, result=0, all internal registers 0. Applies mid-operation; nothing completes.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1 at edge T:
  - Latch op.
  - sign_a = a[31] & (op==01 | op==10); sign_b = b[31] & (op==01).
  - mcand = |a|, mplier = |b| as 32-bit unsigned magnitudes (0x80000000 stays 0x80000000).
  - neg = sign_a ^ sign_b; acc_hi=0; count=0; go to CALC.
- CALC, each edge:
  - {cout,sum} = acc_hi + (mplier[0] ? mcand : 0) via the adder.
  - {acc_hi,acc_lo} <= {cout,sum,acc_lo} >> 1, with acc_lo shifting in sum[0]; mplier >>= 1; count++.
  - After 32 iterations (edge T+32) go to FIX.
- FIX, one edge:
  - If neg, replace the 64-bit product with its two's complement.
  - result <= low word for op=00, high word otherwise.
  - Go to DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
  - Default latency: done high in the cycle following edge T+33.
  - A start in that DONE cycle is ignored. The earliest next accept is the following edge.
- result holds its value until the next FIX. It is never cleared by kill.
- start while busy: ignored. Operands are not re-sampled.
- kill=1 on an edge in CALC or FIX: go to IDLE, no done, result unchanged.
  - kill in DONE: done still pulses (already committed).
  - kill and start together in IDLE: kill wins, no accept.
- Zero operands follow the normal path; latency is unchanged without the optional feature.

Optional Feature:
- MUL_EARLY_EXIT_EN
- Defined:
  - In CALC, if the post-shift mplier is 0, the same edge right-aligns the product by the remaining (32−count) positions and goes to FIX.
  - Latency = n+1 edges after T, where n = max(1, index of highest set bit of |b| + 1).
  - Examples: b=0 gives done after edge T+2; b=6 gives done after edge T+4.
  - Results are bit-identical to the non-feature build.
- Undefined: fixed 32 iterations, done after edge T+33.

Test Plan:
- op=00, a=7, b=6, start at edge T -> done only in the cycle after edge T+33, result=42, busy high from T to done.
- op=01, a=b=0xFFFFFFFF -> result=0x00000000. Repeat with op=00 -> result=0x00000001.
- op=10, a=0xFFFFFFFF, b=0xFFFFFFFF -> result=0xFFFFFFFF. op=11, same operands -> result=0xFFFFFFFE. op=01, a=b=0x80000000 -> result=0x40000000.
- Start op=00 a=3 b=5; assert kill on edge T+10 -> no done, busy=0 after that edge, result keeps prior value. A new start a=2 b=9 on the next edge -> 18.
- Start, then drop rst to 0 at T+5 -> busy, done, result immediately 0. After release, op=11 a=0x10000 b=0x10000 -> result=0x00000001.
- Build with MUL_EARLY_EXIT_EN: op=00 a=7 b=6 -> done after edge T+4, result=42. b=0 -> done after edge T+2, result=0. Without the macro, the same stimulus gives T+33.

Source files
------------

// File: rtl/mul_unit.sv
// mul_unit: iterative shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Sits in EX beside the ALU and holds busy until the 32-bit result is ready.
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-low reset
//   start   in   request, sampled only in IDLE (together with op, a, b)
//   op      in   00=MUL 01=MULH 10=MULHSU 11=MULHU
//   a, b    in   rs1 / rs2 operands
//   kill    in   synchronous pipeline flush (aborts CALC/FIX)
//   busy    out  high in every state except IDLE
//   done    out  one-cycle pulse when result is valid
//   result  out  selected product word, held until the next FIX
//
// Build option: define MUL_EARLY_EXIT_EN to stop iterating once the
// remaining multiplier bits are all zero (results unchanged, lower latency).

module mul_rca32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);

  logic [32:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < 32; i++) begin : g_fa
    assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1]  = (i_a[i] & i_b[i])
                     | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_cout = w_c[32];

endmodule

module mul_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [1:0]  r_op;
  logic        r_neg;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic [31:0] r_acc_hi;
  logic [31:0] r_acc_lo;
  logic [4:0]  r_count;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_result;

  logic        w_sign_a;
  logic        w_sign_b;
  logic [31:0] w_mcand_in;
  logic [31:0] w_mplier_in;
  logic [31:0] w_addend;
  logic [31:0] w_sum;
  logic        w_cout;
  logic [31:0] w_hi_nx;
  logic [31:0] w_lo_nx;
  logic [31:0] w_mplier_nx;
  logic [63:0] w_acc_nx;
  logic        w_last;
  logic [63:0] w_prod;
  logic [63:0] w_prod_fix;

  // rs1 is signed for MULH and MULHSU, rs2 only for MULH.
  assign w_sign_a = a[31] & (op == 2'b01 | op == 2'b10);
  assign w_sign_b = b[31] & (op == 2'b01);

  // Two's-complement magnitude; 0x80000000 maps onto itself, which is
  // exactly 2^31 when read as unsigned.
  assign w_mcand_in  = w_sign_a ? (~a + 32'd1) : a;
  assign w_mplier_in = w_sign_b ? (~b + 32'd1) : b;

  assign w_addend = r_mplier[0] ? r_mcand : 32'd0;

  mul_rca32 u_add (
    .i_a    (r_acc_hi),
    .i_b    (w_addend),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // One shift-add step: carry enters the top, sum[0] drops into acc_lo.
  assign w_hi_nx     = {w_cout, w_sum[31:1]};
  assign w_lo_nx     = {w_sum[0], r_acc_lo[31:1]};
  assign w_mplier_nx = {1'b0, r_mplier[31:1]};

`ifdef MUL_EARLY_EXIT_EN
  logic [5:0] w_shamt;

  // After count+1 steps the product sits 31-count places too high.
  assign w_shamt  = 6'd31 - {1'b0, r_count};
  assign w_last   = (w_mplier_nx == 32'd0) | (r_count == 5'd31);
  assign w_acc_nx = (w_mplier_nx == 32'd0)
                  ? ({w_hi_nx, w_lo_nx} >> w_shamt)
                  : {w_hi_nx, w_lo_nx};
`else
  assign w_last   = (r_count == 5'd31);
  assign w_acc_nx = {w_hi_nx, w_lo_nx};
`endif

  assign w_prod     = {r_acc_hi, r_acc_lo};
  assign w_prod_fix = r_neg ? (~w_prod + 64'd1) : w_prod;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_op     <= 2'b00;
      r_neg    <= 1'b0;
      r_mcand  <= 32'd0;
      r_mplier <= 32'd0;
      r_acc_hi <= 32'd0;
      r_acc_lo <= 32'd0;
      r_count  <= 5'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= 32'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start && !kill) begin
            r_op     <= op;
            r_neg    <= w_sign_a ^ w_sign_b;
            r_mcand  <= w_mcand_in;
            r_mplier <= w_mplier_in;
            r_acc_hi <= 32'd0;
            r_acc_lo <= 32'd0;
            r_count  <= 5'd0;
            r_busy   <= 1'b1;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          if (kill) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            {r_acc_hi, r_acc_lo} <= w_acc_nx;
            r_mplier <= w_mplier_nx;
            r_count  <= r_count + 5'd1;
            if (w_last) begin
              r_state <= S_FIX;
            end
          end
        end
        S_FIX: begin
          if (kill) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_result <= (r_op == 2'b00) ? w_prod_fix[31:0]
                                        : w_prod_fix[63:32];
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          // Already committed: kill and start are both ignored here.
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: directed + random checks of mul_unit against an
// arithmetic reference model (latency, result, handshake, kill, reset).

module tb_mul_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        kill;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;
  logic [31:0] last_exp;

  mul_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .kill   (kill),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(
    input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint xs;
    longint ys;
    logic [63:0] p;
    xs = (o == 2'b01 || o == 2'b10) ? longint'({{32{x[31]}}, x})
                                    : longint'({32'd0, x});
    ys = (o == 2'b01) ? longint'({{32{y[31]}}, y})
                      : longint'({32'd0, y});
    if (o == 2'b11) p = {32'd0, x} * {32'd0, y};
    else            p = 64'(xs * ys);
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic int exp_lat(
    input logic [1:0] o, input logic [31:0] y);
`ifdef MUL_EARLY_EXIT_EN
    logic [31:0] mag;
    int n;
    mag = (o == 2'b01 && y[31]) ? (~y + 32'd1) : y;
    n = 1;
    for (int i = 0; i < 32; i++) if (mag[i]) n = i + 1;
    return n + 1;
`else
    return 33;
`endif
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with the DUT idle.
  task automatic run(input logic [1:0] o, input logic [31:0] x,
                     input logic [31:0] y, input bit poke,
                     input string tag);
    int lat;
    logic [31:0] e;
    e = ref_mul(o, x, y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy0"}, 64'(busy), 64'd1);
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      if (!busy) break;
      if (poke && k == 5) begin
        start = 1'b1; op = 2'($urandom);
        a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat(o, y)));
    chk({tag, "_res"}, 64'(result), 64'(e));
    chk({tag, "_busyd"}, 64'(busy), 64'd1);
    last_exp = e;
    // Start during DONE must be ignored.
    start = 1'b1; op = 2'b00; a = $urandom; b = $urandom;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    chk({tag, "_idle_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] rx;
    logic [31:0] ry;
    rst = 1'b0; start = 1'b0; kill = 1'b0;
    op = 2'b00; a = 32'd0; b = 32'd0;
    last_exp = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    run(2'b00, 32'd7, 32'd6, 1'b1, "mul_7x6");
    chk("mul_7x6_val", 64'(result), 64'd42);
    run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulh_m1");
    chk("mulh_m1_val", 64'(result), 64'h0);
    run(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mul_m1");
    chk("mul_m1_val", 64'(result), 64'h1);
    run(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulhsu_m1");
    chk("mulhsu_m1_val", 64'(result), 64'hFFFF_FFFF);
    run(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulhu_m1");
    chk("mulhu_m1_val", 64'(result), 64'hFFFF_FFFE);
    run(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0, "mulh_min");
    chk("mulh_min_val", 64'(result), 64'h4000_0000);
    run(2'b00, 32'd1234, 32'd0, 1'b0, "mul_b0");
    chk("mul_b0_val", 64'(result), 64'h0);
    run(2'b01, 32'd5, 32'h8000_0000, 1'b0, "mulh_bmin");

    // kill and start together in IDLE: no accept
    start = 1'b1; kill = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    chk("killstart_busy", 64'(busy), 64'd0);

    // kill in CALC
    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) begin
      @(posedge clk);
      @(negedge clk);
    end
    kill = 1'b1;
    @(posedge clk);
    @(negedge clk);
    kill = 1'b0;
    chk("kill_busy", 64'(busy), 64'd0);
    chk("kill_done", 64'(done), 64'd0);
    chk("kill_result", 64'(result), 64'(last_exp));
    run(2'b00, 32'd2, 32'd9, 1'b0, "after_kill");
    chk("after_kill_val", 64'(result), 64'd18);

    // asynchronous reset mid-operation
    start = 1'b1; op = 2'b00; a = $urandom; b = $urandom;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_result", 64'(result), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run(2'b11, 32'h0001_0000, 32'h0001_0000, 1'b0, "post_rst");
    chk("post_rst_val", 64'(result), 64'd1);

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom);
      rx = $urandom;
      ry = $urandom;
      if (i % 4 == 1) ry = ry >> $urandom_range(31, 0);
      if (i % 6 == 2) rx = 32'h8000_0000;
      run(ro, rx, ry, i[0], $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
